// File: rtl/hdu_pkg.sv
// hdu_pkg: shared entry type, default sizes and stall-cause codes for the
// long-latency hazard scoreboard; supplies width macros when the build lacks them.
`ifndef REG_ADDR_WIDTH
`define REG_ADDR_WIDTH 5
`endif
`ifndef EX_INFO_BUS_WIDTH
`define EX_INFO_BUS_WIDTH 4
`endif
`ifndef EX_INFO_ALU
`define EX_INFO_ALU 4'd1
`endif
`ifndef EX_INFO_BYPASS_BIT
`define EX_INFO_BYPASS_BIT 3
`endif

package hdu_pkg;
    localparam int SCB_DEPTH      = 8;
    localparam int SCB_NUM_COMMIT = 2;

    typedef struct packed {
        logic [`REG_ADDR_WIDTH-1:0]    rd_addr;
        logic [`EX_INFO_BUS_WIDTH-1:0] exu_type;
    } scb_entry_t;

    typedef enum logic [1:0] {
        STALL_NONE,
        STALL_RAW,
        STALL_WAW,
        STALL_FULL
    } stall_cause_e;
endpackage

// File: rtl/scb_alloc_enc.sv
// scb_alloc_enc: lowest-index free entry finder plus popcount of the valid vector.
// Ports: valid_vec in; free_id, free_found, count out.
module scb_alloc_enc
    import hdu_pkg::*;
#(
    parameter int DEPTH = SCB_DEPTH,
    parameter int ID_W  = $clog2(DEPTH)
) (
    input  logic [DEPTH-1:0] valid_vec,
    output logic [ID_W-1:0]  free_id,
    output logic             free_found,
    output logic [ID_W:0]    count
);
    always_comb begin
        free_id    = '0;
        free_found = 1'b0;
        count      = '0;
        // Scan downward so the last hit is the lowest free index.
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!valid_vec[i]) begin
                free_id    = ID_W'(i);
                free_found = 1'b1;
            end
            count = count + (ID_W + 1)'(valid_vec[i]);
        end
    end
endmodule

// File: rtl/long_inst_scoreboard.sv
// long_inst_scoreboard: RAW/WAW hazard tracking for long-latency writers with
// commit-ID allocation, multi-port retire and epoch-tagged flush.
// Ports: dispatch (inst_valid_i, rd_*, rs_*, ex_info_i), commit ports,
// flush_i; outputs stall/alloc/ID/epoch/raw hits/occupancy/spurious/counters.
// Optional: SCB_PERF_CNT_EN builds the saturating stall counters.
module long_inst_scoreboard
    import hdu_pkg::*;
#(
    parameter int DEPTH      = SCB_DEPTH,
    parameter int ID_W       = $clog2(DEPTH),
    parameter int NUM_COMMIT = SCB_NUM_COMMIT,
    parameter int NUM_RS     = 3,
    parameter int REG_ADDR_W = `REG_ADDR_WIDTH,
    parameter int EXU_W      = `EX_INFO_BUS_WIDTH
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         inst_valid_i,
    input  logic [REG_ADDR_W-1:0]        rd_addr_i,
    input  logic                         rd_we_i,
    input  logic [NUM_RS*REG_ADDR_W-1:0] rs_addr_i,
    input  logic [NUM_RS-1:0]            rs_re_i,
    input  logic [EXU_W-1:0]             ex_info_i,
    input  logic [NUM_COMMIT-1:0]        commit_valid_i,
    input  logic [NUM_COMMIT*ID_W-1:0]   commit_id_i,
    input  logic [NUM_COMMIT-1:0]        commit_epoch_i,
    input  logic                         flush_i,
    output logic                         hazard_stall_o,
    output logic                         alloc_o,
    output logic [ID_W-1:0]              commit_id_o,
    output logic                         epoch_o,
    output logic [NUM_RS-1:0]            raw_rs_o,
    output logic                         atom_lock_o,
    output logic [ID_W:0]                occupancy_o,
    output logic                         spurious_commit_o,
    output logic [31:0]                  raw_stall_cnt_o,
    output logic [31:0]                  waw_stall_cnt_o,
    output logic [31:0]                  full_stall_cnt_o
);
    scb_entry_t       entries_q [DEPTH];
    logic [DEPTH-1:0] valid_q;
    logic             epoch_q;
    logic             trk_valid_q;
    logic [ID_W-1:0]  trk_id_q;
    logic             spurious_q;

    logic [DEPTH-1:0] retire;
    logic [DEPTH-1:0] live;
    logic [DEPTH-1:0] alloc_vec;
    logic             spurious_d;
    logic             raw_any;
    logic             waw_any;
    logic             full_stall;
    logic             rd_nz;
    logic [ID_W-1:0]  free_id;
    logic             free_found;

    scb_alloc_enc #(
        .DEPTH (DEPTH),
        .ID_W  (ID_W)
    ) u_enc (
        .valid_vec  (valid_q),
        .free_id    (free_id),
        .free_found (free_found),
        .count      (occupancy_o)
    );

    // Commits in a flush cycle are dropped without flagging them.
    always_comb begin
        retire     = '0;
        spurious_d = 1'b0;
        for (int p = 0; p < NUM_COMMIT; p++) begin
            if (commit_valid_i[p] && !flush_i) begin
                if (valid_q[commit_id_i[p*ID_W +: ID_W]] &&
                    commit_epoch_i[p] == epoch_q)
                    retire[commit_id_i[p*ID_W +: ID_W]] = 1'b1;
                else
                    spurious_d = 1'b1;
            end
        end
    end

    assign live  = valid_q & ~retire;
    assign rd_nz = rd_addr_i != '0;

    // The last ALU writer's result is forwarded to bypass-class readers.
    always_comb begin
        raw_rs_o = '0;
        raw_any  = 1'b0;
        waw_any  = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            for (int k = 0; k < NUM_RS; k++) begin
                if (live[i] && rs_re_i[k] &&
                    rs_addr_i[k*REG_ADDR_W +: REG_ADDR_W] ==
                    entries_q[i].rd_addr) begin
                    raw_rs_o[k] = 1'b1;
                    if (!(trk_valid_q && trk_id_q == ID_W'(i) &&
                          !ex_info_i[`EX_INFO_BYPASS_BIT]))
                        raw_any = 1'b1;
                end
            end
            if (live[i] && rd_we_i && rd_nz &&
                rd_addr_i == entries_q[i].rd_addr &&
                ex_info_i != entries_q[i].exu_type)
                waw_any = 1'b1;
        end
    end

    assign full_stall = (occupancy_o == (ID_W + 1)'(DEPTH)) &&
                        rd_we_i && rd_nz;

    assign hazard_stall_o = inst_valid_i && !flush_i &&
                            (raw_any || waw_any || full_stall);

    assign alloc_o = inst_valid_i && rd_we_i && rd_nz && free_found &&
                     !hazard_stall_o && !flush_i;

    assign commit_id_o       = alloc_o ? free_id : '0;
    assign alloc_vec         = alloc_o ? (DEPTH'(1) << free_id) : '0;
    assign epoch_o           = epoch_q;
    assign atom_lock_o       = |valid_q;
    assign spurious_commit_o = spurious_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q     <= '0;
            epoch_q     <= 1'b0;
            trk_valid_q <= 1'b0;
            trk_id_q    <= '0;
            spurious_q  <= 1'b0;
        end else if (flush_i) begin
            valid_q     <= '0;
            epoch_q     <= ~epoch_q;
            trk_valid_q <= 1'b0;
            spurious_q  <= 1'b0;
        end else begin
            valid_q    <= live | alloc_vec;
            spurious_q <= spurious_d;
            if (alloc_o && ex_info_i == `EX_INFO_ALU) begin
                trk_valid_q <= 1'b1;
                trk_id_q    <= free_id;
            end else if (trk_valid_q && retire[trk_id_q]) begin
                trk_valid_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (alloc_o) begin
            entries_q[free_id].rd_addr  <= rd_addr_i;
            entries_q[free_id].exu_type <= ex_info_i;
        end
    end

`ifdef SCB_PERF_CNT_EN
    stall_cause_e cause;
    logic [31:0]  raw_cnt_q;
    logic [31:0]  waw_cnt_q;
    logic [31:0]  full_cnt_q;

    always_comb begin
        cause = STALL_NONE;
        if (hazard_stall_o) begin
            if (raw_any)      cause = STALL_RAW;
            else if (waw_any) cause = STALL_WAW;
            else              cause = STALL_FULL;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            raw_cnt_q  <= '0;
            waw_cnt_q  <= '0;
            full_cnt_q <= '0;
        end else begin
            if (cause == STALL_RAW && raw_cnt_q != '1)
                raw_cnt_q <= raw_cnt_q + 32'd1;
            if (cause == STALL_WAW && waw_cnt_q != '1)
                waw_cnt_q <= waw_cnt_q + 32'd1;
            if (cause == STALL_FULL && full_cnt_q != '1)
                full_cnt_q <= full_cnt_q + 32'd1;
        end
    end

    assign raw_stall_cnt_o  = raw_cnt_q;
    assign waw_stall_cnt_o  = waw_cnt_q;
    assign full_stall_cnt_o = full_cnt_q;
`else
    assign raw_stall_cnt_o  = '0;
    assign waw_stall_cnt_o  = '0;
    assign full_stall_cnt_o = '0;
`endif
endmodule

// File: tb/tb_long_inst_scoreboard.sv
// tb_long_inst_scoreboard: directed plus random dispatch/commit/flush traffic
// against a queue-based reference model, checked by a decoupled monitor.
module tb_long_inst_scoreboard;
    localparam int DEPTH = 8;
    localparam int IW    = 3;
    localparam int NC    = 2;
    localparam int NRS   = 3;
    localparam int RW    = 5;
    localparam int EW    = 4;
    localparam int ALU   = 1;
    localparam int MUL   = 2;
    localparam int DIV   = 3;
    localparam int NBYP  = 9;

    logic             clk = 1'b0;
    logic             rst;
    logic             inst_valid_i;
    logic [RW-1:0]    rd_addr_i;
    logic             rd_we_i;
    logic [NRS*RW-1:0] rs_addr_i;
    logic [NRS-1:0]   rs_re_i;
    logic [EW-1:0]    ex_info_i;
    logic [NC-1:0]    commit_valid_i;
    logic [NC*IW-1:0] commit_id_i;
    logic [NC-1:0]    commit_epoch_i;
    logic             flush_i;
    logic             hazard_stall_o;
    logic             alloc_o;
    logic [IW-1:0]    commit_id_o;
    logic             epoch_o;
    logic [NRS-1:0]   raw_rs_o;
    logic             atom_lock_o;
    logic [IW:0]      occupancy_o;
    logic             spurious_commit_o;
    logic [31:0]      raw_stall_cnt_o;
    logic [31:0]      waw_stall_cnt_o;
    logic [31:0]      full_stall_cnt_o;

    long_inst_scoreboard #(
        .DEPTH(DEPTH), .ID_W(IW), .NUM_COMMIT(NC), .NUM_RS(NRS),
        .REG_ADDR_W(RW), .EXU_W(EW)
    ) dut (
        .clk(clk), .rst(rst),
        .inst_valid_i(inst_valid_i), .rd_addr_i(rd_addr_i),
        .rd_we_i(rd_we_i), .rs_addr_i(rs_addr_i), .rs_re_i(rs_re_i),
        .ex_info_i(ex_info_i), .commit_valid_i(commit_valid_i),
        .commit_id_i(commit_id_i), .commit_epoch_i(commit_epoch_i),
        .flush_i(flush_i), .hazard_stall_o(hazard_stall_o),
        .alloc_o(alloc_o), .commit_id_o(commit_id_o), .epoch_o(epoch_o),
        .raw_rs_o(raw_rs_o), .atom_lock_o(atom_lock_o),
        .occupancy_o(occupancy_o), .spurious_commit_o(spurious_commit_o),
        .raw_stall_cnt_o(raw_stall_cnt_o), .waw_stall_cnt_o(waw_stall_cnt_o),
        .full_stall_cnt_o(full_stall_cnt_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        int id;
        int rd;
        int exu;
    } ent_t;

    typedef struct {
        bit       stall;
        bit       alloc;
        int       id;
        bit [2:0] raw;
        int       occ;
        bit       spur;
        bit       epoch;
        bit       lock;
        longint   rc;
        longint   wc;
        longint   fc;
    } exp_t;

    ent_t   fl[$];
    exp_t   expq[$];
    bit     m_epoch;
    bit     trk_v;
    int     trk_id;
    bit     m_spur;
    longint raw_cnt;
    longint waw_cnt;
    longint full_cnt;
    int     nchk;
    int     nerr;

    function automatic bit in_flight(int id);
        foreach (fl[j]) if (fl[j].id == id) return 1'b1;
        return 1'b0;
    endfunction

    // Model one cycle from the currently driven inputs, queue expectations.
    task automatic step();
        exp_t e;
        bit   retm [DEPTH];
        bit   nspur;
        bit   rawm;
        bit   waw;
        bit   full;
        int   rd;
        ent_t n;
        ent_t keep[$];
        e.occ   = fl.size();
        e.epoch = m_epoch;
        e.spur  = m_spur;
        e.lock  = fl.size() != 0;
        e.rc    = raw_cnt;
        e.wc    = waw_cnt;
        e.fc    = full_cnt;
        e.raw   = '0;
        nspur   = 1'b0;
        rawm    = 1'b0;
        waw     = 1'b0;
        rd      = int'(rd_addr_i);
        foreach (retm[i]) retm[i] = 1'b0;
        if (!flush_i) begin
            for (int p = 0; p < NC; p++) begin
                if (commit_valid_i[p]) begin
                    int c;
                    c = int'(commit_id_i[p*IW +: IW]);
                    if (in_flight(c) && commit_epoch_i[p] == m_epoch)
                        retm[c] = 1'b1;
                    else
                        nspur = 1'b1;
                end
            end
        end
        foreach (fl[j]) begin
            if (!retm[fl[j].id]) begin
                for (int k = 0; k < NRS; k++) begin
                    if (rs_re_i[k] &&
                        int'(rs_addr_i[k*RW +: RW]) == fl[j].rd) begin
                        e.raw[k] = 1'b1;
                        if (!(trk_v && trk_id == fl[j].id &&
                              ex_info_i[3] == 1'b0))
                            rawm = 1'b1;
                    end
                end
                if (rd_we_i && rd != 0 && rd == fl[j].rd &&
                    int'(ex_info_i) != fl[j].exu)
                    waw = 1'b1;
            end
        end
        full    = fl.size() == DEPTH && rd_we_i && rd != 0;
        e.stall = inst_valid_i && !flush_i && (rawm || waw || full);
        e.alloc = inst_valid_i && rd_we_i && rd != 0 &&
                  !e.stall && !flush_i;
        e.id    = 0;
        if (e.alloc) begin
            for (int i = DEPTH - 1; i >= 0; i--)
                if (!in_flight(i)) e.id = i;
        end
        expq.push_back(e);
`ifdef SCB_PERF_CNT_EN
        if (e.stall) begin
            if (rawm)      raw_cnt++;
            else if (waw)  waw_cnt++;
            else           full_cnt++;
        end
`endif
        if (flush_i) begin
            fl.delete();
            trk_v   = 1'b0;
            m_epoch = ~m_epoch;
            m_spur  = 1'b0;
        end else begin
            foreach (fl[j]) if (!retm[fl[j].id]) keep.push_back(fl[j]);
            fl = keep;
            if (e.alloc) begin
                n.id  = e.id;
                n.rd  = rd;
                n.exu = int'(ex_info_i);
                fl.push_back(n);
            end
            if (e.alloc && int'(ex_info_i) == ALU) begin
                trk_v  = 1'b1;
                trk_id = e.id;
            end else if (trk_v && retm[trk_id]) begin
                trk_v = 1'b0;
            end
            m_spur = nspur;
        end
    endtask

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d at %0t",
                     nm, act, exp, $time);
        end
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (expq.size() > 0) begin
                e = expq.pop_front();
                chk("stall", 64'(hazard_stall_o), 64'(e.stall));
                chk("alloc", 64'(alloc_o), 64'(e.alloc));
                chk("commit_id", 64'(commit_id_o), 64'(e.id));
                chk("raw_rs", 64'(raw_rs_o), 64'(e.raw));
                chk("occupancy", 64'(occupancy_o), 64'(e.occ));
                chk("spurious", 64'(spurious_commit_o), 64'(e.spur));
                chk("epoch", 64'(epoch_o), 64'(e.epoch));
                chk("atom_lock", 64'(atom_lock_o), 64'(e.lock));
                chk("raw_cnt", 64'(raw_stall_cnt_o), 64'(e.rc));
                chk("waw_cnt", 64'(waw_stall_cnt_o), 64'(e.wc));
                chk("full_cnt", 64'(full_stall_cnt_o), 64'(e.fc));
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic clr();
        inst_valid_i   = 1'b0;
        rd_addr_i      = '0;
        rd_we_i        = 1'b0;
        rs_addr_i      = '0;
        rs_re_i        = '0;
        ex_info_i      = '0;
        commit_valid_i = '0;
        commit_id_i    = '0;
        commit_epoch_i = '0;
        flush_i        = 1'b0;
    endtask

    task automatic go();
        step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(int rd, int ex);
        clr();
        inst_valid_i = 1'b1;
        rd_we_i      = 1'b1;
        rd_addr_i    = RW'(rd);
        ex_info_i    = EW'(ex);
    endtask

    task automatic rdr(int k, int r, int ex);
        inst_valid_i          = 1'b1;
        ex_info_i             = EW'(ex);
        rs_re_i[k]            = 1'b1;
        rs_addr_i[k*RW +: RW] = RW'(r);
    endtask

    task automatic cm(int p, int id, bit ep);
        commit_valid_i[p]         = 1'b1;
        commit_id_i[p*IW +: IW]   = IW'(id);
        commit_epoch_i[p]         = ep;
    endtask

    task automatic do_flush();
        clr();
        flush_i = 1'b1;
        go();
    endtask

    task automatic rand_inputs();
        int exs [4];
        exs = '{ALU, MUL, DIV, NBYP};
        clr();
        inst_valid_i = ($urandom_range(0, 9) < 8);
        rd_we_i      = ($urandom_range(0, 9) < 8);
        rd_addr_i    = RW'($urandom_range(0, 6));
        ex_info_i    = EW'(exs[$urandom_range(0, 3)]);
        for (int k = 0; k < NRS; k++) begin
            rs_re_i[k]            = $urandom_range(0, 1);
            rs_addr_i[k*RW +: RW] = RW'($urandom_range(0, 6));
        end
        for (int p = 0; p < NC; p++) begin
            if ($urandom_range(0, 9) < 4) begin
                if (fl.size() > 0 && $urandom_range(0, 99) < 85)
                    cm(p, fl[$urandom_range(0, fl.size() - 1)].id, m_epoch);
                else
                    cm(p, $urandom_range(0, DEPTH - 1), 1'($urandom_range(0, 1)));
            end
        end
        flush_i = ($urandom_range(0, 99) < 3);
    endtask

    initial begin
        nchk = 0; nerr = 0;
        m_epoch = 1'b0; trk_v = 1'b0; trk_id = 0; m_spur = 1'b0;
        raw_cnt = 0; waw_cnt = 0; full_cnt = 0;
        clr();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        // reset state, then RAW against a MUL writer and commit release
        clr(); go();
        wr(5, MUL); go();
        clr(); rdr(0, 5, ALU); go();
        clr(); rdr(0, 5, ALU); cm(0, 0, m_epoch); go();
        // ALU bypass masking
        do_flush();
        wr(7, ALU); go();
        clr(); rdr(0, 7, ALU); go();
        clr(); rdr(0, 7, NBYP); go();
        // fill, full stall, retire ID 3 and reallocate
        do_flush();
        for (int i = 0; i < DEPTH; i++) begin wr(10 + i, MUL); go(); end
        wr(20, MUL); go();
        clr(); cm(0, 3, m_epoch); go();
        wr(21, MUL); go();
        clr(); go();
        // flush with live entries, late commit with old epoch
        do_flush();
        for (int i = 0; i < 4; i++) begin wr(1 + i, DIV); go(); end
        do_flush();
        clr(); cm(0, 0, ~m_epoch); go();
        wr(3, MUL); go();
        clr(); go();
        // duplicate commit on both ports
        do_flush();
        for (int i = 0; i < 3; i++) begin wr(1 + i, MUL); go(); end
        clr(); cm(0, 2, m_epoch); cm(1, 2, m_epoch); go();
        clr(); go();
        // WAW across and within unit types
        do_flush();
        wr(9, MUL); go();
        wr(9, DIV); go();
        do_flush();
        wr(9, MUL); go();
        wr(9, MUL); go();
        // five-cycle RAW stall for the counters
        do_flush();
        wr(5, MUL); go();
        for (int i = 0; i < 5; i++) begin clr(); rdr(0, 5, ALU); go(); end
        clr(); go();
        // random traffic
        for (int n = 0; n < 2000; n++) begin rand_inputs(); go(); end
        clr(); go(); go();
        @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule

// File: doc/long_inst_scoreboard.md
Name: long_inst_scoreboard

Overview:
Parametrised next-generation hazard scoreboard for long-latency instructions (MUL/DIV/CSR/FP/LSU) at dispatch. Tracks up to DEPTH in-flight register writers and detects RAW/WAW hazards against them. Allocates a commit ID per accepted writer and retires entries from NUM_COMMIT completion ports. Adds flush with epoch tagging, so late commits from killed instructions cannot retire reallocated IDs.

Parameters:
DEPTH, 8, number of tracked entries (power of 2, 2..32)
ID_W, $clog2(DEPTH), commit ID width
NUM_COMMIT, 2, number of completion ports
NUM_RS, 3, number of source operands checked
REG_ADDR_W, `REG_ADDR_WIDTH, register address width
EXU_W, `EX_INFO_BUS_WIDTH, execution-unit tag width

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
inst_valid_i  in  1  dispatching instruction valid
rd_addr_i  in  REG_ADDR_W  destination register
rd_we_i  in  1  instruction writes rd
rs_addr_i  in  NUM_RS*REG_ADDR_W  source registers, operand k at [k*REG_ADDR_W +: REG_ADDR_W]
rs_re_i  in  NUM_RS  per-operand check enable
ex_info_i  in  EXU_W  execution-unit tag
commit_valid_i  in  NUM_COMMIT  per-port completion valid
commit_id_i  in  NUM_COMMIT*ID_W  per-port completing ID
commit_epoch_i  in  NUM_COMMIT  epoch bit carried with the completing instruction
flush_i  in  1  kill all in-flight entries
hazard_stall_o  out  1  stall dispatch
alloc_o  out  1  writer accepted and entry allocated this cycle
commit_id_o  out  ID_W  ID allocated (0 when alloc_o=0)
epoch_o  out  1  current epoch, to be carried with the instruction
raw_rs_o  out  NUM_RS  per-operand raw RAW hit, before the bypass mask
atom_lock_o  out  1  any entry valid
occupancy_o  out  ID_W+1  number of valid entries
spurious_commit_o  out  1  registered pulse for an ignored commit
raw_stall_cnt_o, waw_stall_cnt_o, full_stall_cnt_o  out  32 each  performance counters

Behaviour:
- Reset (rst=1 at a clk edge): all entries invalid, epoch=0, bypass tracker invalid, occupancy_o=0, spurious_commit_o=0, counters=0. All combinational outputs then read 0 while inst_valid_i=0.
- Live entry: valid and not retired this cycle. Port p retires entry i when commit_valid_i[p], commit_id_i[p]==i, commit_epoch_i[p]==epoch and entry i is valid.
- Ignored commit: a commit to an invalid entry or with a mismatched epoch is ignored and sets spurious_commit_o=1 on the next cycle.
- Duplicate commit: two ports retiring the same ID in one cycle clear it once.
- RAW: an operand k with rs_re_i[k] and rs_addr==entry.rd of a live entry. raw_rs_o[k] reflects this hit.
- WAW: rd_we_i and rd_addr_i==entry.rd of a live entry with a different exu_type. Same-type WAW is allowed (in-order unit).
- x0 writes are never allocated and never cause WAW.
- Bypass mask: the tracker holds the ID of the last accepted writer with ex_info_i==`EX_INFO_ALU. When ex_info_i[`EX_INFO_BYPASS_BIT]==0, RAW hits on that entry alone are masked.
  - Tracker clears when its ID retires or on flush.
  - A new ALU accept in the same cycle as the retire wins.
- full = occupancy_o==DEPTH, using registered occupancy. IDs freed this cycle are not reallocatable until the next cycle.
- hazard_stall_o = inst_valid_i & ~flush_i & (masked RAW | WAW | (full & rd_we_i & rd!=0)).
- alloc_o = inst_valid_i & rd_we_i & rd_addr_i!=0 & ~hazard_stall_o & ~flush_i.
  - commit_id_o = lowest-index non-valid entry.
  - The entry becomes valid next cycle with rd and exu_type stored.
- Flush (flush_i=1, takes priority over all else):
  - next cycle all entries are invalid, the tracker is invalid, occupancy is 0 and epoch toggles;
  - no allocation occurs in the flush cycle;
  - commits in the flush cycle are ignored silently.
- Occupancy: occupancy_o always equals the popcount of the valid vector and updates the cycle after each accept, retire or flush.
- Latency: hazard detection and allocation are combinational within one cycle; state updates on the next edge.

Optional Feature:
SCB_PERF_CNT_EN:
- Defined: three saturating 32-bit counters increment once per stalled cycle.
  - Priority when several causes apply: RAW, then WAW, then full.
  - Counters clear on rst only, not on flush.
- Undefined: the counter ports remain present and are tied to 0; no counter flops are built.

Decomposition:
- Package hdu_pkg: scb_entry_t (rd_addr, exu_type), default DEPTH/NUM_COMMIT constants, stall-cause enum.
- Sub-module scb_alloc_enc: parametrised lowest-free priority encoder plus popcount over the valid vector.

Test Plan:
- Accept MUL writing x5 (ID 0); next-cycle ALU reading x5 -> hazard_stall_o=1, raw_rs_o[0]=1; commit ID 0 with epoch 0 -> stall drops in the same cycle.
- Accept ALU writing x7 (ID 0); bypass-class instruction reading x7 -> no stall, raw_rs_o=1; a non-bypass reader stalls.
- Fill 8 entries; 9th writer -> stall with full cause. Retire ID 3 -> the next cycle allocates ID 3 and occupancy_o reads 8→7→8.
- Flush with 4 entries live -> occupancy 0 and epoch=1. A late commit of ID 0 with epoch 0 -> ignored and spurious_commit_o=1. A new accept then gets ID 0.
- Both ports commit ID 2 in one cycle -> occupancy drops by exactly 1. MUL followed by DIV, both writing x9 -> WAW stall; MUL then MUL -> no stall.
- With SCB_PERF_CNT_EN, a 5-cycle RAW stall -> raw_stall_cnt_o=5 and the other counters stay 0.
